// File: rtl/sb_pkg.sv
// Register scoreboard package: default geometry, address/counter types
// and the per-register counter ceiling. Optional feature macro used by the
// scoreboard: SB_RETIRE_BYPASS_EN.
package sb_pkg;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int NRD   = 2;
  localparam int TOT_W = 4;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Maximum in-flight writers one register can track.
  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/sb_counter.sv
// One saturating up/down pending-write counter. clr wins over inc/dec;
// inc together with dec leaves the count unchanged.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full
);

  assign zero = (cnt == '0);
  assign full = (cnt == '1);

  // Count state: clear, else step up or down, never wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (inc && !dec && !full)   cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero)   cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard beside decode: one pending-write counter per
// architectural register (r0 untracked), RAW/overflow stall generation
// for issue, and a saturating total of in-flight writes.
// Optional: SB_RETIRE_BYPASS_EN lets a retire in the current cycle clear
// a last pending write for rd_busy and free a slot for the full check.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG  = sb_pkg::NREG,
  parameter int AW    = sb_pkg::AW,
  parameter int CNT_W = sb_pkg::CNT_W,
  parameter int NRD   = sb_pkg::NRD,
  parameter int TOT_W = sb_pkg::TOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_dest,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic              issue_ready,
  output logic [NRD-1:0]    rd_busy,
  input  logic              retire_valid,
  input  logic              retire_we,
  input  logic [AW-1:0]     retire_dest,
  input  logic              flush,
  output logic [TOT_W-1:0]  inflight_total,
  output logic              busy_any
);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            zero, full, nz;
  logic [NREG-1:0]            dest_oh, ret_oh;
  logic                       ret_act, issue_full, inc_any, dec_any;

  // One-hot register decode; bit 0 stays low so r0 never matches.
  function automatic logic [NREG-1:0] dec1h(input logic [AW-1:0] a);
    logic [NREG-1:0] o;
    o = '0;
    for (int r = 1; r < NREG; r++) o[r] = (a == AW'(r));
    return o;
  endfunction

  assign cnt[0]  = '0;
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;

  assign dest_oh = dec1h(issue_dest);
  assign ret_oh  = dec1h(retire_dest);
  assign ret_act = retire_valid && retire_we;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_any && dest_oh[r]),
        .dec   (ret_act && ret_oh[r]),
        .clr   (flush),
        .cnt   (cnt[r]),
        .zero  (zero[r]),
        .full  (full[r])
      );
    end
    for (r = 0; r < NREG; r++) begin : g_nz
      assign nz[r] = (cnt[r] != '0);
    end
  endgenerate

`ifdef SB_RETIRE_BYPASS_EN
  logic [NREG-1:0] one;
  generate
    for (r = 0; r < NREG; r++) begin : g_one
      assign one[r] = (cnt[r] == CNT_W'(1));
    end
  endgenerate

  // Full destination blocks issue unless a retire to it frees a slot now.
  assign issue_full = issue_we && |(full & dest_oh) &&
                      !(ret_act && (retire_dest == issue_dest));

  // Per-port RAW check; a retire draining the last writer bypasses it.
  always_comb begin
    logic [NREG-1:0] a_oh;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a_oh       = dec1h(rd_addr[i*AW +: AW]);
      rd_busy[i] = rd_en[i] && |(nz & a_oh) &&
                   !(ret_act && |(one & a_oh & ret_oh));
    end
  end
`else
  // Full destination blocks issue until a retire has been registered.
  assign issue_full = issue_we && |(full & dest_oh);

  // Per-port RAW check against registered counters only.
  always_comb begin
    logic [NREG-1:0] a_oh;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a_oh       = dec1h(rd_addr[i*AW +: AW]);
      rd_busy[i] = rd_en[i] && |(nz & a_oh);
    end
  end
`endif

  assign issue_ready = !(|rd_busy) && !issue_full;
  assign inc_any     = issue_valid && issue_ready && issue_we && |dest_oh;
  assign dec_any     = ret_act && |(~zero & ret_oh);
  assign busy_any    = (inflight_total != '0);

  // Total in-flight writes, stepped by the same terms as the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        inflight_total <= '0;
    else if (flush)                                   inflight_total <= '0;
    else if (inc_any && !dec_any && inflight_total != '1)
      inflight_total <= inflight_total + 1'b1;
    else if (dec_any && !inc_any && inflight_total != '0)
      inflight_total <= inflight_total - 1'b1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: each step drives one cycle of inputs
// and queues the expected outputs; a monitor compares on the falling edge.
module tb_reg_scoreboard;

`ifdef SB_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid, issue_we, retire_valid, retire_we, flush;
  logic [4:0]  issue_dest, retire_dest;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        issue_ready, busy_any;
  logic [1:0]  rd_busy;
  logic [3:0]  inflight_total;

  typedef struct {
    string      name;
    logic [1:0] busy;
    logic       rdy;
    logic [3:0] tot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .issue_ready(issue_ready), .rd_busy(rd_busy),
    .retire_valid(retire_valid), .retire_we(retire_we), .retire_dest(retire_dest),
    .flush(flush), .inflight_total(inflight_total), .busy_any(busy_any)
  );

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd_busy !== e.busy) begin
        errors++;
        $display("FAIL %s rd_busy got %b want %b", e.name, rd_busy, e.busy);
      end
      checks++;
      if (issue_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s issue_ready got %b want %b", e.name, issue_ready, e.rdy);
      end
      checks++;
      if (inflight_total !== e.tot) begin
        errors++;
        $display("FAIL %s inflight_total got %0d want %0d", e.name, inflight_total, e.tot);
      end
      checks++;
      if (busy_any !== (e.tot != 4'd0)) begin
        errors++;
        $display("FAIL %s busy_any got %b want %b", e.name, busy_any, e.tot != 4'd0);
      end
    end
  end

  // Advance to just after the next rising edge and drive one cycle.
  task automatic step(input logic iv, input logic iwe, input logic [4:0] idest,
                      input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1,
                      input logic rv, input logic [4:0] rdest, input logic fl);
    @(posedge clk);
    #1;
    issue_valid  = iv;
    issue_we     = iwe;
    issue_dest   = idest;
    rd_en        = ren;
    rd_addr      = {a1, a0};
    retire_valid = rv;
    retire_we    = rv;
    retire_dest  = rdest;
    flush        = fl;
  endtask

  task automatic expect_out(input string n, input logic [1:0] b,
                            input logic rdy, input logic [3:0] t);
    exp_t e;
    e.name = n; e.busy = b; e.rdy = rdy; e.tot = t;
    exp_q.push_back(e);
  endtask

  initial begin
    issue_valid = 0; issue_we = 0; issue_dest = 0; rd_en = 0; rd_addr = 0;
    retire_valid = 0; retire_we = 0; retire_dest = 0; flush = 0;

    step(0,0,0, 2'b00,0,0, 0,0,0); expect_out("rst_init", 2'b00, 1, 0);
    // build r5 = 2, then async reset mid-operation
    reset = 0;
    step(1,1,5, 2'b00,0,0, 0,0,0); expect_out("r5_iss1", 2'b00, 1, 0);
    step(1,1,5, 2'b00,0,0, 0,0,0); expect_out("r5_iss2", 2'b00, 1, 1);
    step(0,0,0, 2'b01,5,0, 0,0,0); expect_out("r5_busy", 2'b01, 0, 2);
    step(0,0,0, 2'b01,5,0, 0,0,0); reset = 1; expect_out("rst_async", 2'b00, 1, 0);
    step(0,0,0, 2'b01,5,0, 0,0,0); reset = 0; expect_out("rst_hold", 2'b00, 1, 0);
    // RAW on r4 and its release
    step(1,1,4, 2'b00,0,0, 0,0,0); expect_out("r4_iss", 2'b00, 1, 0);
    step(0,0,0, 2'b01,4,0, 0,0,0); expect_out("r4_raw", 2'b01, 0, 1);
    step(0,0,0, 2'b01,4,0, 1,4,0); expect_out("r4_ret", BYP ? 2'b00 : 2'b01, BYP, 1);
    step(0,0,0, 2'b01,4,0, 0,0,0); expect_out("r4_clear", 2'b00, 1, 0);
    // fill r7 to its ceiling
    step(1,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_iss1", 2'b00, 1, 0);
    step(1,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_iss2", 2'b00, 1, 1);
    step(1,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_iss3", 2'b00, 1, 2);
    step(1,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_full", 2'b00, 0, 3);
    step(1,1,7, 2'b00,0,0, 1,7,0); expect_out("r7_ret", 2'b00, BYP, 3);
    step(1,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_acc", 2'b00, !BYP, BYP ? 4'd3 : 4'd2);
    step(0,1,7, 2'b00,0,0, 0,0,0); expect_out("r7_refull", 2'b00, 0, 3);
    step(0,0,0, 2'b00,0,0, 1,7,0); expect_out("r7_drain3", 2'b00, 1, 3);
    step(0,0,0, 2'b00,0,0, 1,7,0); expect_out("r7_drain2", 2'b00, 1, 2);
    step(0,0,0, 2'b00,0,0, 1,7,0); expect_out("r7_drain1", 2'b00, 1, 1);
    step(0,0,0, 2'b00,0,0, 0,0,0); expect_out("r7_empty", 2'b00, 1, 0);
    // same-cycle issue and retire on r9
    step(1,1,9, 2'b00,0,0, 0,0,0); expect_out("r9_iss", 2'b00, 1, 0);
    step(1,1,9, 2'b00,0,0, 1,9,0); expect_out("r9_same", 2'b00, 1, 1);
    step(0,0,0, 2'b01,9,0, 0,0,0); expect_out("r9_keep", 2'b01, 0, 1);
    step(0,0,0, 2'b00,0,0, 1,9,0); expect_out("r9_ret", 2'b00, 1, 1);
    step(0,0,0, 2'b00,0,0, 0,0,0); expect_out("r9_empty", 2'b00, 1, 0);
    // r0 writes and retire to an idle register
    step(1,1,0, 2'b11,0,12, 1,12,0); expect_out("r0_r12", 2'b00, 1, 0);
    step(1,1,0, 2'b11,0,12, 0,0,0);  expect_out("r0_after", 2'b00, 1, 0);
    step(0,0,0, 2'b01,0,0, 0,0,0);   expect_out("r0_rd", 2'b00, 1, 0);
    // flush discards everything, including a same-cycle issue
    step(1,1,3, 2'b00,0,0, 0,0,0);  expect_out("fl_iss3", 2'b00, 1, 0);
    step(1,1,8, 2'b00,0,0, 0,0,0);  expect_out("fl_iss8", 2'b00, 1, 1);
    step(1,1,10, 2'b00,0,0, 1,3,1); expect_out("flush_cyc", 2'b00, 1, 2);
    step(0,0,0, 2'b11,10,3, 0,0,0); expect_out("flush_after", 2'b00, 1, 0);
    step(0,0,0, 2'b01,8,0, 0,0,0);  expect_out("flush_r8", 2'b00, 1, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
